// File: rtl/timer_irq_ctrl.sv
// Timer interrupt aggregator. Latches rising edges of the timer irq lines into a
// pending register, masks them, and holds one prioritised request until it is acked by ID.
module timer_irq_ctrl #(
  parameter  int CHANNELS = 8,
  localparam int SRCS     = CHANNELS + 1,
  localparam int IDW      = $clog2(CHANNELS + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CHANNELS-1:0] t_irq,
  input  logic            tc_irq,
  input  logic            mask_wen,
  input  logic [SRCS-1:0] mask_wdata,
  input  logic            ack,
  input  logic [IDW-1:0]  ack_id,
  output logic            irq,
  output logic [IDW-1:0]  irq_id,
  output logic [SRCS-1:0] pending,
  output logic [SRCS-1:0] mask,
  output logic [SRCS-1:0] overrun,
  output logic            ack_err
);

  // state  | meaning
  // IDLE   | no request presented; arbitrate over pending & mask
  // ACTIVE | irq=1, irq_id frozen until a matching ack or the source is masked
  // GAP    | one forced irq=0 cycle after an ack before re-arbitration
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t          state;
  logic [SRCS-1:0] src, src_q, src_rise, cand, id_onehot, clr;
  logic [IDW-1:0]  win_id;
  logic            ack_ok;

  assign src       = {tc_irq, t_irq};
  assign src_rise  = src & ~src_q;
  assign cand      = pending & mask;
  assign id_onehot = SRCS'(1) << irq_id;
  assign ack_ok    = ack && (state == ACTIVE) && (ack_id == irq_id);
  assign clr       = ack_ok ? id_onehot : '0;

  // Ascending scan so the highest-numbered candidate is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < SRCS; i++) begin
      if (cand[i]) win_id = IDW'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
      overrun <= '0;
      ack_err <= 1'b0;
    end else begin
      src_q   <= src;
      // A new edge beats the ack clear on pending, but the ack still clears overrun.
      pending <= (pending & ~clr) | src_rise;
      overrun <= (overrun | (src_rise & pending)) & ~clr;
      ack_err <= ack && !ack_ok;
      if (mask_wen) mask <= mask_wdata;

      case (state)
        IDLE: begin
          if (|cand) begin
            irq_id <= win_id;
            irq    <= 1'b1;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ack_ok) begin
            irq   <= 1'b0;
            state <= GAP;
          end else if (!(|(mask & id_onehot))) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: state <= IDLE;
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: directed scenarios with fixed expectations, then
// random traffic compared against a cycle-level behavioural model.
module tb_timer_irq_ctrl;
  localparam int CH  = 8;
  localparam int S   = CH + 1;
  localparam int IDW = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [CH-1:0]  t_irq;
  logic           tc_irq;
  logic           mask_wen;
  logic [S-1:0]   mask_wdata;
  logic           ack;
  logic [IDW-1:0] ack_id;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic [S-1:0]   pending, mask, overrun;
  logic           ack_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [S-1:0] m_pend, m_mask, m_ovr, m_srcq;
  logic         m_irq, m_err;
  int           m_id, m_cool;

  timer_irq_ctrl #(.CHANNELS(CH)) dut (
    .CLK(CLK), .RST(RST), .t_irq(t_irq), .tc_irq(tc_irq),
    .mask_wen(mask_wen), .mask_wdata(mask_wdata), .ack(ack), .ack_id(ack_id),
    .irq(irq), .irq_id(irq_id), .pending(pending), .mask(mask),
    .overrun(overrun), .ack_err(ack_err)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_ovr = '0; m_srcq = '0;
    m_irq = 1'b0; m_err = 1'b0; m_id = 0; m_cool = 0;
  endtask

  // One clock of the documented behaviour, from the inputs seen at the edge.
  task automatic model_step();
    logic [S-1:0] src, rise, clr, cand;
    logic valid;
    int w;
    src   = {tc_irq, t_irq};
    rise  = src & ~m_srcq;
    cand  = m_pend & m_mask;
    valid = ack && m_irq && (int'(ack_id) == m_id);
    clr   = '0;
    if (valid) clr[m_id] = 1'b1;
    m_err  = ack && !valid;
    m_ovr  = (m_ovr | (rise & m_pend)) & ~clr;
    m_pend = (m_pend & ~clr) | rise;
    m_srcq = src;
    if (m_irq) begin
      if (valid) begin
        m_irq = 1'b0; m_cool = 1;
      end else if (!m_mask[m_id]) begin
        m_irq = 1'b0;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (cand != '0) begin
      w = -1;
      for (int i = S - 1; i >= 0; i--) if (cand[i] && w < 0) w = i;
      m_id  = w;
      m_irq = 1'b1;
    end
    if (mask_wen) m_mask = mask_wdata;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    ack      = 1'b0;
    mask_wen = 1'b0;
  endtask

  task automatic do_ack(input int id);
    ack = 1'b1; ack_id = IDW'(id);
  endtask

  task automatic set_mask(input logic [S-1:0] v);
    mask_wen = 1'b1; mask_wdata = v;
  endtask

  task automatic test_reset();
    RST = 1'b1; t_irq = '0; tc_irq = 1'b0; mask_wen = 1'b0; mask_wdata = '0;
    ack = 1'b0; ack_id = '0;
    model_reset();
    #1;
    n_cmp++;
    if ({irq, irq_id, pending, mask, overrun, ack_err} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got irq=%b id=%0d pend=%b mask=%b ovr=%b err=%b want all 0",
               irq, irq_id, pending, mask, overrun, ack_err);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_basic();
    set_mask('1); tick();
    t_irq[3] = 1'b1; tick();
    n_cmp++;
    if (pending !== 9'h008 || irq !== 1'b0) begin
      n_err++; $display("FAIL basic_pend: got pend=%h irq=%b want pend=008 irq=0", pending, irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1 || irq_id !== 4'd3) begin
      n_err++; $display("FAIL basic_irq: got irq=%b id=%0d want irq=1 id=3", irq, irq_id);
    end
    do_ack(3); tick();
    n_cmp++;
    if (irq !== 1'b0 || pending !== '0) begin
      n_err++; $display("FAIL basic_ack: got irq=%b pend=%h want irq=0 pend=0", irq, pending);
    end
    t_irq[3] = 1'b0; tick(); tick();
  endtask

  task automatic test_priority();
    int order [3] = '{8, 5, 1};
    t_irq[1] = 1'b1; t_irq[5] = 1'b1; tc_irq = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (irq !== 1'b1 || irq_id !== IDW'(order[k])) begin
        n_err++; $display("FAIL prio_order%0d: got irq=%b id=%0d want irq=1 id=%0d", k, irq, irq_id, order[k]);
      end
      do_ack(order[k]); tick();
      n_cmp++;
      if (irq !== 1'b0) begin
        n_err++; $display("FAIL prio_gap%0d: got irq=%b want 0", k, irq);
      end
      tick();
      if (k < 2) begin
        n_cmp++;
        if (irq !== 1'b0) begin
          n_err++; $display("FAIL prio_gap2_%0d: got irq=%b want 0", k, irq);
        end
      end
      tick();
    end
    t_irq = '0; tc_irq = 1'b0; tick();
  endtask

  task automatic test_frozen();
    t_irq[2] = 1'b1; tick(); tick();
    t_irq[6] = 1'b1; tick(); tick(); tick();
    n_cmp++;
    if (irq !== 1'b1 || irq_id !== 4'd2) begin
      n_err++; $display("FAIL frozen_id: got irq=%b id=%0d want irq=1 id=2", irq, irq_id);
    end
    do_ack(2); tick(); tick(); tick();
    n_cmp++;
    if (irq !== 1'b1 || irq_id !== 4'd6) begin
      n_err++; $display("FAIL frozen_next: got irq=%b id=%0d want irq=1 id=6", irq, irq_id);
    end
    do_ack(6); tick();
    t_irq = '0; tick(); tick();
  endtask

  task automatic test_overrun();
    t_irq[0] = 1'b1; tick();
    t_irq[0] = 1'b0; tick();
    t_irq[0] = 1'b1; tick();
    t_irq[0] = 1'b0; tick();
    n_cmp++;
    if (overrun !== 9'h001 || irq !== 1'b1 || irq_id !== 4'd0) begin
      n_err++; $display("FAIL ovr_set: got ovr=%h irq=%b id=%0d want ovr=001 irq=1 id=0", overrun, irq, irq_id);
    end
    do_ack(0); tick();
    n_cmp++;
    if (overrun !== '0 || pending !== '0) begin
      n_err++; $display("FAIL ovr_clr: got ovr=%h pend=%h want 0 0", overrun, pending);
    end
    tick(); tick();
  endtask

  task automatic test_set_wins();
    t_irq[4] = 1'b1; tick();
    t_irq[4] = 1'b0; tick();
    t_irq[4] = 1'b1; tick();
    t_irq[4] = 1'b0; tick();
    t_irq[4] = 1'b1; do_ack(4); tick();
    n_cmp++;
    if (pending !== 9'h010 || overrun !== '0 || irq !== 1'b0) begin
      n_err++; $display("FAIL setwins: got pend=%h ovr=%h irq=%b want pend=010 ovr=0 irq=0", pending, overrun, irq);
    end
    tick(); tick();
    n_cmp++;
    if (irq !== 1'b1 || irq_id !== 4'd4) begin
      n_err++; $display("FAIL setwins_reserve: got irq=%b id=%0d want irq=1 id=4", irq, irq_id);
    end
    t_irq[4] = 1'b0; do_ack(4); tick(); tick(); tick();
  endtask

  task automatic test_ack_err();
    t_irq[2] = 1'b1; tick(); tick();
    do_ack(4); tick();
    n_cmp++;
    if (ack_err !== 1'b1 || irq !== 1'b1 || irq_id !== 4'd2) begin
      n_err++; $display("FAIL ackerr_wrong: got err=%b irq=%b id=%0d want err=1 irq=1 id=2", ack_err, irq, irq_id);
    end
    tick();
    n_cmp++;
    if (ack_err !== 1'b0) begin
      n_err++; $display("FAIL ackerr_pulse: got err=%b want 0", ack_err);
    end
    do_ack(2); tick(); tick();
    do_ack(2); tick();
    n_cmp++;
    if (ack_err !== 1'b1 || irq !== 1'b0) begin
      n_err++; $display("FAIL ackerr_idle: got err=%b irq=%b want err=1 irq=0", ack_err, irq);
    end
    t_irq[2] = 1'b0; tick();
  endtask

  task automatic test_mask_drop();
    t_irq[7] = 1'b1; tick(); tick();
    set_mask(9'h17F); tick();
    tick();
    n_cmp++;
    if (irq !== 1'b0 || pending[7] !== 1'b1 || ack_err !== 1'b0) begin
      n_err++; $display("FAIL mask_drop: got irq=%b pend7=%b err=%b want irq=0 pend7=1 err=0", irq, pending[7], ack_err);
    end
    set_mask('1); tick(); tick();
    n_cmp++;
    if (irq !== 1'b1 || irq_id !== 4'd7) begin
      n_err++; $display("FAIL mask_reenable: got irq=%b id=%0d want irq=1 id=7", irq, irq_id);
    end
    t_irq[7] = 1'b0; do_ack(7); tick(); tick(); tick();
  endtask

  task automatic test_reset_active();
    t_irq[5] = 1'b1; tick(); tick();
    #2 RST = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({irq, pending, mask, overrun} !== '0) begin
      n_err++; $display("FAIL rst_active: got irq=%b pend=%h mask=%h ovr=%h want all 0", irq, pending, mask, overrun);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    set_mask('1); tick();
    n_cmp++;
    if (pending !== 9'h020) begin
      n_err++; $display("FAIL rst_recapture: got pend=%h want 020", pending);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1 || irq_id !== 4'd5) begin
      n_err++; $display("FAIL rst_reserve: got irq=%b id=%0d want irq=1 id=5", irq, irq_id);
    end
    t_irq[5] = 1'b0; do_ack(5); tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      t_irq  = t_irq ^ CH'($urandom & $urandom & $urandom);
      tc_irq = ($urandom_range(0, 7) == 0) ? ~tc_irq : tc_irq;
      if ($urandom_range(0, 15) == 0) set_mask(S'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        ack    = 1'b1;
        ack_id = ($urandom_range(0, 2) != 0) ? IDW'(m_id) : IDW'($urandom_range(0, 15));
      end
      tick();
      n_cmp++;
      if ({irq, pending, mask, overrun, ack_err} !== {m_irq, m_pend, m_mask, m_ovr, m_err}) begin
        n_err++;
        $display("FAIL rand_c%0d: got irq=%b pend=%h mask=%h ovr=%h err=%b want irq=%b pend=%h mask=%h ovr=%h err=%b",
                 c, irq, pending, mask, overrun, ack_err, m_irq, m_pend, m_mask, m_ovr, m_err);
      end
      if (m_irq) begin
        n_cmp++;
        if (irq_id !== IDW'(m_id)) begin
          n_err++; $display("FAIL rand_id_c%0d: got id=%0d want %0d", c, irq_id, m_id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_frozen();
    test_overrun();
    test_set_wins();
    test_ack_err();
    test_mask_drop();
    test_reset_active();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
